// File: rtl/fib_lookup_arbiter.sv
// Round-robin arbiter sharing one FIB lookup engine between NUM_REQ requesters,
// with an in-order tag FIFO routing results back. Optional stats: FIB_ARB_STATS_EN.
module fib_lookup_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int POINTER_SIZE    = 16,
  parameter int MAX_INFLIGHT    = 8,
  localparam int NW = MAX_NAME_LENGTH * WORD_SIZE,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_INFLIGHT + 1),
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*NW-1:0]     req_name,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      lk_valid,
  output logic [NW-1:0]             lk_name,
  input  logic                      lk_ready,
  input  logic                      rs_valid,
  input  logic [POINTER_SIZE-1:0]   rs_ptr,
  input  logic                      rs_hit,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [POINTER_SIZE-1:0]   resp_ptr,
  output logic                      resp_hit,
  output logic [CW-1:0]             inflight,
  output logic                      err_unexp
`ifdef FIB_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  function automatic logic [NUM_REQ-1:0] tag_onehot(input logic [IW-1:0] tag);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag == IW'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  logic [IW-1:0]           rr_ptr_r;
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [IW-1:0]           tag_mem_r [MAX_INFLIGHT];
  logic [CW-1:0]           inflight_r;
  logic                    lk_valid_r;
  logic [NW-1:0]           lk_name_r;
  logic [NUM_REQ-1:0]      resp_valid_r;
  logic [POINTER_SIZE-1:0] resp_ptr_r;
  logic                    resp_hit_r;
  logic                    err_unexp_r;

  logic                    can_issue_s;
  logic                    found_s;
  logic [IW-1:0]           gidx_s;
  logic                    grant_fire_s;
  logic [NUM_REQ-1:0]      grant_vec_s;
  logic [NW-1:0]           grant_name_s;
  logic [IW-1:0]           next_rr_s;
  logic                    pop_s;
  logic [IW-1:0]           head_tag_s;

  // Occupancy before this cycle's pop is used, so a full FIFO blocks issue even when a result pops
  assign can_issue_s  = !rst && (!lk_valid_r || lk_ready) && (inflight_r < CW'(MAX_INFLIGHT));
  assign grant_fire_s = found_s && can_issue_s;
  assign pop_s        = rs_valid && (inflight_r != '0);
  assign head_tag_s   = tag_mem_r[rd_ptr_r];
  assign next_rr_s    = (gidx_s == IW'(NUM_REQ - 1)) ? '0 : gidx_s + IW'(1);

  // Round-robin search for the first valid requester starting at rr_ptr_r
  always_comb begin
    logic [IW:0] sum_v;
    found_s = 1'b0;
    gidx_s  = '0;
    sum_v   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_v = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (sum_v >= (IW+1)'(NUM_REQ)) begin
        sum_v = sum_v - (IW+1)'(NUM_REQ);
      end else begin
        sum_v = sum_v;
      end
      if (!found_s && req_valid[sum_v[IW-1:0]]) begin
        found_s = 1'b1;
        gidx_s  = sum_v[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot accept vector and selected name
  always_comb begin
    grant_vec_s  = '0;
    grant_name_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_s == IW'(i)) begin
        grant_vec_s[i] = grant_fire_s;
        grant_name_s   = req_name[i*NW +: NW];
      end else begin
        grant_vec_s[i] = 1'b0;
      end
    end
  end

  // Tag storage; entries are meaningful only between rd_ptr_r and wr_ptr_r
  always_ff @(posedge clk) begin
    if (grant_fire_s) begin
      tag_mem_r[wr_ptr_r] <= gidx_s;
    end
  end

  // Issue stage, tag FIFO pointers, result return and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      inflight_r   <= '0;
      lk_valid_r   <= 1'b0;
      lk_name_r    <= '0;
      resp_valid_r <= '0;
      resp_ptr_r   <= '0;
      resp_hit_r   <= 1'b0;
      err_unexp_r  <= 1'b0;
    end else begin
      if (grant_fire_s) begin
        lk_valid_r <= 1'b1;
        lk_name_r  <= grant_name_s;
        rr_ptr_r   <= next_rr_s;
        wr_ptr_r   <= wr_ptr_r + PW'(1);
      end else if (lk_ready) begin
        lk_valid_r <= 1'b0;
      end

      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + PW'(1);
        resp_valid_r <= tag_onehot(head_tag_s);
        resp_ptr_r   <= rs_ptr;
        resp_hit_r   <= rs_hit;
      end else begin
        resp_valid_r <= '0;
      end

      if (rs_valid && (inflight_r == '0)) begin
        err_unexp_r <= 1'b1;
      end

      case ({grant_fire_s, pop_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

`ifdef FIB_ARB_STATS_EN
  logic [31:0] stat_issued_r;
  logic [31:0] stat_stall_r;

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_r <= 32'd0;
      stat_stall_r  <= 32'd0;
    end else begin
      if (grant_fire_s && (stat_issued_r != 32'hFFFF_FFFF)) begin
        stat_issued_r <= stat_issued_r + 32'd1;
      end
      if ((|req_valid) && !grant_fire_s && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_issued = stat_issued_r;
  assign stat_stall  = stat_stall_r;
`endif

  assign req_ready  = grant_vec_s;
  assign lk_valid   = lk_valid_r;
  assign lk_name    = lk_name_r;
  assign resp_valid = resp_valid_r;
  assign resp_ptr   = resp_ptr_r;
  assign resp_hit   = resp_hit_r;
  assign inflight   = inflight_r;
  assign err_unexp  = err_unexp_r;

endmodule

// File: tb/tb_fib_lookup_arbiter.sv
// Bench for fib_lookup_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fib_lookup_arbiter;
  localparam int NR = 4;
  localparam int WS = 32;
  localparam int ML = 8;
  localparam int PS = 16;
  localparam int MI = 8;
  localparam int NW = ML * WS;
  localparam int CW = $clog2(MI + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*NW-1:0] req_name;
  logic [NR-1:0]    req_ready;
  logic             lk_valid;
  logic [NW-1:0]    lk_name;
  logic             lk_ready;
  logic             rs_valid;
  logic [PS-1:0]    rs_ptr;
  logic             rs_hit;
  logic [NR-1:0]    resp_valid;
  logic [PS-1:0]    resp_ptr;
  logic             resp_hit;
  logic [CW-1:0]    inflight;
  logic             err_unexp;
`ifdef FIB_ARB_STATS_EN
  logic [31:0]      stat_issued;
  logic [31:0]      stat_stall;
`endif

  fib_lookup_arbiter #(
    .NUM_REQ(NR), .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML),
    .POINTER_SIZE(PS), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_name(req_name),
    .req_ready(req_ready), .lk_valid(lk_valid), .lk_name(lk_name),
    .lk_ready(lk_ready), .rs_valid(rs_valid), .rs_ptr(rs_ptr), .rs_hit(rs_hit),
    .resp_valid(resp_valid), .resp_ptr(resp_ptr), .resp_hit(resp_hit),
    .inflight(inflight), .err_unexp(err_unexp)
`ifdef FIB_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int            q[$];
  bit            m_lkv;
  logic [NW-1:0] m_name;
  int            m_rr;
  bit            m_err;
  logic [NR-1:0] m_respv;
  logic [PS-1:0] m_rptr;
  bit            m_rhit;
  int            m_gnt;
  longint        m_issued;
  longint        m_stall;

  typedef struct {
    bit        rst;
    logic [3:0] rv;
    bit        lkr;
    bit        rsv;
    logic [15:0] ptr;
    bit        hit;
    logic [3:0] e_ready;
    bit        e_lkv;
    int        e_src;
    int        e_infl;
    logic [3:0] e_respv;
    logic [15:0] e_ptr;
    bit        e_hit;
    bit        e_err;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [NW-1:0] name_of(input int i);
    return req_name[i*NW +: NW];
  endfunction

  task automatic new_names();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < ML; j++)
        req_name[(i*ML+j)*WS +: WS] = {8'(i + 1), 8'(j), 16'($urandom)};
  endtask

  task automatic model_reset();
    q.delete();
    m_lkv = 1'b0; m_name = '0; m_rr = 0; m_err = 1'b0;
    m_respv = '0; m_rptr = '0; m_rhit = 1'b0; m_issued = 0; m_stall = 0;
  endtask

  // Compare every output against the model, mid-cycle
  task automatic sample();
    @(negedge clk);
    m_gnt = -1;
    if (!rst && (!m_lkv || lk_ready) && q.size() < MI)
      for (int k = 0; k < NR; k++)
        if (m_gnt < 0 && req_valid[(m_rr + k) % NR]) m_gnt = (m_rr + k) % NR;
    chk("req_ready", NW'(req_ready), (m_gnt >= 0) ? NW'(1 << m_gnt) : NW'(0));
    chk("lk_valid", NW'(lk_valid), NW'(m_lkv));
    if (m_lkv) chk("lk_name", lk_name, m_name);
    chk("inflight", NW'(inflight), NW'(q.size()));
    chk("resp_valid", NW'(resp_valid), NW'(m_respv));
    if (m_respv != '0) begin
      chk("resp_ptr", NW'(resp_ptr), NW'(m_rptr));
      chk("resp_hit", NW'(resp_hit), NW'(m_rhit));
    end
    chk("err_unexp", NW'(err_unexp), NW'(m_err));
`ifdef FIB_ARB_STATS_EN
    chk("stat_issued", NW'(stat_issued), NW'(m_issued[31:0]));
    chk("stat_stall", NW'(stat_stall), NW'(m_stall[31:0]));
`endif
  endtask

  // Apply the clock edge to the model and the DUT
  task automatic advance();
    int t;
    if (rst) begin
      model_reset();
    end else begin
      m_respv = '0;
      if (rs_valid) begin
        if (q.size() > 0) begin
          t = q.pop_front();
          m_respv[t] = 1'b1;
          m_rptr = rs_ptr;
          m_rhit = rs_hit;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_gnt >= 0) begin
        q.push_back(m_gnt);
        m_lkv = 1'b1;
        m_name = name_of(m_gnt);
        m_rr = (m_gnt + 1) % NR;
        m_issued++;
      end else begin
        if (lk_ready) m_lkv = 1'b0;
        if (|req_valid) m_stall++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; lk_ready = 1'b1; rs_valid = 1'b0;
    sample();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    rst = 1'b1; req_valid = '0; lk_ready = 1'b1; rs_valid = 1'b0;
    rs_ptr = '0; rs_hit = 1'b0;
    new_names();
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Result routing and unexpected result
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, -1, 0, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 1'b0, -1, 0, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 1'b1,  3, 1, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0100, 1'b1,  0, 2, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 16'h0011, 1'b1, 4'b0000, 1'b1,  2, 3, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 16'h0022, 1'b0, 4'b0000, 1'b0, -1, 2, 4'b1000, 16'h0011, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 16'h0033, 1'b1, 4'b0000, 1'b0, -1, 1, 4'b0001, 16'h0022, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, -1, 0, 4'b0100, 16'h0033, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 16'h0044, 1'b1, 4'b0000, 1'b0, -1, 0, 4'b0000, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, -1, 0, 4'b0000, 16'h0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, -1, 0, 4'b0000, 16'h0000, 1'b0, 1'b1};
    for (int r = 0; r < 11; r++) begin
      rst = tbl[r].rst; req_valid = tbl[r].rv; lk_ready = tbl[r].lkr;
      rs_valid = tbl[r].rsv; rs_ptr = tbl[r].ptr; rs_hit = tbl[r].hit;
      sample();
      chk($sformatf("tbl%0d.req_ready", r), NW'(req_ready), NW'(tbl[r].e_ready));
      chk($sformatf("tbl%0d.lk_valid", r), NW'(lk_valid), NW'(tbl[r].e_lkv));
      if (tbl[r].e_src >= 0) chk($sformatf("tbl%0d.lk_name", r), lk_name, name_of(tbl[r].e_src));
      chk($sformatf("tbl%0d.inflight", r), NW'(inflight), NW'(tbl[r].e_infl));
      chk($sformatf("tbl%0d.resp_valid", r), NW'(resp_valid), NW'(tbl[r].e_respv));
      if (tbl[r].e_respv != 4'b0000) begin
        chk($sformatf("tbl%0d.resp_ptr", r), NW'(resp_ptr), NW'(tbl[r].e_ptr));
        chk($sformatf("tbl%0d.resp_hit", r), NW'(resp_hit), NW'(tbl[r].e_hit));
      end
      chk($sformatf("tbl%0d.err_unexp", r), NW'(err_unexp), NW'(tbl[r].e_err));
      advance();
    end

    // Reset with 5 in flight, then a stray result
    rs_valid = 1'b0; req_valid = 4'b1111; lk_ready = 1'b1;
    repeat (5) begin sample(); advance(); end
    req_valid = '0;
    sample();
    chk("pre_rst.inflight", NW'(inflight), NW'(5));
    advance();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0; rs_valid = 1'b1; rs_ptr = 16'h0055;
    sample();
    chk("post_rst.inflight", NW'(inflight), NW'(0));
    chk("post_rst.lk_valid", NW'(lk_valid), NW'(0));
    chk("post_rst.err_unexp", NW'(err_unexp), NW'(0));
    advance();
    rs_valid = 1'b0; req_valid = 4'b1111;
    sample();
    chk("stray.err_unexp", NW'(err_unexp), NW'(1));
    chk("stray.resp_valid", NW'(resp_valid), NW'(0));
    chk("post_rst.rr_first", NW'(req_ready), NW'(4'b0001));
    advance();

    // Full load, results 4 cycles after acceptance
    do_reset();
    for (int c = 0; c < 20; c++) begin
      req_valid = 4'b1111; lk_ready = 1'b1; rs_valid = (c >= 4);
      rs_ptr = 16'($urandom); rs_hit = 1'($urandom);
      sample();
      chk($sformatf("rr%0d.req_ready", c), NW'(req_ready), NW'(1 << (c % 4)));
      if (c >= 4) chk($sformatf("rr%0d.inflight", c), NW'(inflight), NW'(4));
      if (c >= 5) chk($sformatf("rr%0d.resp_valid", c), NW'(resp_valid), NW'(1 << ((c - 5) % 4)));
      advance();
    end

    // Backpressure holds lk_name, then requester 2 wins on release
    do_reset();
    req_valid = 4'b0110; lk_ready = 1'b0;
    sample();
    chk("bp.first_grant", NW'(req_ready), NW'(4'b0010));
    advance();
    repeat (2) begin
      sample();
      chk("bp.no_grant", NW'(req_ready), NW'(0));
      chk("bp.lk_name_held", lk_name, name_of(1));
      advance();
    end
    lk_ready = 1'b1;
    sample();
    chk("bp.release_grant", NW'(req_ready), NW'(4'b0100));
    advance();
    req_valid = '0;
    sample();
    chk("bp.lk_name2", lk_name, name_of(2));
    chk("bp.inflight", NW'(inflight), NW'(2));
    advance();

    // FIFO full
    do_reset();
    grants = 0;
    req_valid = 4'b1111; lk_ready = 1'b1; rs_valid = 1'b0;
    repeat (12) begin
      sample();
      if (req_ready != '0) grants++;
      advance();
    end
    chk("full.grants", NW'(grants), NW'(MI));
    rs_valid = 1'b1; rs_ptr = 16'h0077; rs_hit = 1'b1;
    sample();
    chk("full.inflight", NW'(inflight), NW'(MI));
    chk("full.no_grant_on_pop", NW'(req_ready), NW'(0));
    advance();
    rs_valid = 1'b0;
    sample();
    chk("full.inflight_after_pop", NW'(inflight), NW'(MI - 1));
    chk("full.regrant", NW'(req_ready != '0), NW'(1));
    advance();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom);
      lk_ready = ($urandom_range(0, 3) != 0);
      rs_valid = (q.size() > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
      rs_ptr = 16'($urandom); rs_hit = 1'($urandom);
      if ($urandom_range(0, 15) == 0) new_names();
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fib_lookup_arbiter.md
# fib_lookup_arbiter

Round-robin scheduler that shares one FIB lookup engine between `NUM_REQ` name requesters (e.g. per-face interest queues). It accepts full names from the requesters, issues one name per cycle to the engine through a registered valid/ready stage, and records the issuing requester in an in-order tag FIFO. It routes each engine result back to the requester that issued it. The block sits between the face-side name extractors and the tree-based FIB lookup top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WORD_SIZE`, 32: bits per name word.
- `MAX_NAME_LENGTH`, 8: words per name; unused trailing words are zero.
- `POINTER_SIZE`, 16: width of the FIB result pointer.
- `MAX_INFLIGHT`, 8: tag FIFO depth; power of 2, 2..32.

Let NW = `MAX_NAME_LENGTH*WORD_SIZE`, IW = clog2(`NUM_REQ`), CW = clog2(`MAX_INFLIGHT`+1).

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: requester i has a name pending.
- `req_name` in `NUM_REQ`*NW: name of requester i in slice [i*NW +: NW], word 0 in the LSBs.
- `req_ready` out `NUM_REQ`: one-hot accept for this cycle; combinational from state and `req_valid`.
- `lk_valid` out 1: name presented to the engine.
- `lk_name` out NW: registered name.
- `lk_ready` in 1: engine accepts when `lk_valid && lk_ready`.
- `rs_valid` in 1: engine result strobe; results return in issue order and cannot be stalled.
- `rs_ptr` in `POINTER_SIZE`: result pointer.
- `rs_hit` in 1: match found.
- `resp_valid` out `NUM_REQ`: one-hot result strobe to the owning requester.
- `resp_ptr` out `POINTER_SIZE`: registered copy of `rs_ptr`.
- `resp_hit` out 1: registered copy of `rs_hit`.
- `inflight` out CW: tag FIFO occupancy.
- `err_unexp` out 1: sticky; set by `rs_valid` while the tag FIFO is empty.

## Operation
- **Issue condition:** `can_issue = (!lk_valid || lk_ready) && (inflight < MAX_INFLIGHT)`. The occupancy used is the value before this cycle's pop, which is deliberately conservative.
- **Arbitration:** round-robin, searching from `rr_ptr` upward with wrap. The first i with `req_valid[i]` is granted when `can_issue`. `req_ready[i]` is asserted only for that i; all other bits are 0.
- **On grant:**
  - `lk_name <= req_name[i]`, `lk_valid <= 1`.
  - Push i into the tag FIFO.
  - `rr_ptr <= (i+1) mod NUM_REQ`.
- **No grant:** `lk_valid` clears when `lk_ready`; otherwise `lk_valid` and `lk_name` hold stable.
- **Result return:** on `rs_valid` with a non-empty FIFO:
  - Pop head tag t.
  - Next cycle: `resp_valid[t] = 1`, `resp_ptr`/`resp_hit` loaded from the result.
- **Unexpected result:** `rs_valid` with an empty FIFO is dropped, no pop; `err_unexp <= 1`. Only `rst` clears `err_unexp`.
- **Simultaneous push and pop:** both take effect; `inflight` is unchanged.
- **Occupancy:** `inflight` counts issued names (including one held in `lk_name`) that have no result yet. Pointers wrap modulo `MAX_INFLIGHT`.
- **Reset values:** `lk_valid`=0, `lk_name`=0, `resp_valid`=0, `resp_ptr`=0, `resp_hit`=0, `inflight`=0, `err_unexp`=0, `rr_ptr`=0 (requester 0 has first priority). `req_ready` is 0 during reset.
- **Reset mid-operation:** all in-flight tags are discarded. A result arriving after reset sets `err_unexp`.

## Timing
- Request accepted at cycle T -> `lk_valid` at T+1.
- `rs_valid` at cycle R -> `resp_valid` at R+1, a 1-cycle pulse.
- Sustained throughput: 1 issue/cycle while `lk_ready`=1 and `inflight` < `MAX_INFLIGHT`.
- No combinational path from `rs_*` to any output. `req_ready` depends combinationally on `req_valid`, `lk_ready` and registered state.

## Configuration
- **Macro:** `FIB_ARB_STATS_EN`.
- **When defined, adds two outputs:**
  - `stat_issued` out 32: count of grants.
  - `stat_stall` out 32: count of cycles where `|req_valid` is true and no grant is made.
- **Counter behaviour:** both saturate at 2^32-1 and reset to 0.
- **When undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Round-robin under full load:** `NUM_REQ`=4, all `req_valid`=1, `lk_ready`=1, results returned 3 cycles after issue -> grants in order 0,1,2,3,0,…; each `resp_valid` one-hot matches the issue order; `inflight` settles at 4.
- **Backpressure:** `lk_ready`=0 with requesters 1 and 2 valid -> one grant (1), `lk_name` held stable, no further `req_ready`. Raise `lk_ready` -> requester 2 is granted the same cycle.
- **FIFO full:** `MAX_INFLIGHT`=8, no results -> exactly 8 grants, then `req_ready`=0. One `rs_valid` -> `inflight` drops to 7 and one new grant follows on the next cycle.
- **Result routing:** issue from requesters 3,0,2; return ptrs 0x0011 (hit), 0x0022 (miss), 0x0033 (hit) -> `resp_valid` = 4'b1000, 4'b0001, 4'b0100 with matching `resp_ptr`/`resp_hit`.
- **Error and reset:** `rs_valid` with an empty FIFO -> `err_unexp`=1, no `resp_valid`. Assert `rst` with 5 in flight -> `inflight`=0, `lk_valid`=0, `rr_ptr`=0, `err_unexp`=0.
- **Stats (`FIB_ARB_STATS_EN`):** 10 grants plus 4 stalled cycles -> `stat_issued`=10, `stat_stall`=4.
